// File: rtl/multi_counter_pkg.sv
// Register map, CTRL bit positions and reset values shared by multi_counter and its channels.
package multi_counter_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_COUNT  = 2'd1,
        REG_LIMIT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    localparam int unsigned CTRL_W       = 4;
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_DIR     = 1;
    localparam int unsigned CTRL_ONESHOT = 2;
    localparam int unsigned CTRL_IRQ_EN  = 3;

    localparam logic [CTRL_W-1:0] CTRL_RST = '0;

    // Expands the four byte strobes into a 32-bit bit-enable mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter/timer channel: CTRL/COUNT/LIMIT/STATUS registers with step, limit compare and sticky hit.
module counter_channel
    import multi_counter_pkg::*;
#(
    parameter int unsigned BITS       = 30,
    parameter int unsigned COUNT_STEP = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_i,
    input  reg_sel_e          sel_i,
    input  logic [31:0]       wmask_i,
    input  logic [31:0]       wdata_i,
    input  logic              force_i,
    input  logic [BITS-1:0]   force_mask_i,
    input  logic [BITS-1:0]   force_val_i,
    output logic [BITS-1:0]   count_o,
    output logic [BITS-1:0]   limit_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              hit_o
);

    localparam logic [BITS:0] STEP = (BITS+1)'(COUNT_STEP);

    logic [BITS-1:0]   count_q, count_d, limit_q, limit_d, step_cnt;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              hit_q, hit_d, step_hit, do_step;
    logic [BITS:0]     sum;
    logic [BITS-1:0]   wmask, wdata;
    logic              unused_bus_bits;

    assign wmask           = wmask_i[BITS-1:0];
    assign wdata           = wdata_i[BITS-1:0];
    assign unused_bus_bits = ^{wmask_i, wdata_i};

    // Sum is one bit wider so COUNT+STEP past the top of the range still clamps to LIMIT.
    always_comb begin
        step_hit = 1'b0;
        step_cnt = count_q;
        sum      = {1'b0, count_q} + STEP;
        if (!ctrl_q[CTRL_DIR]) begin
            if (count_q >= limit_q) begin
                step_hit = 1'b1;
                if (!ctrl_q[CTRL_ONESHOT]) step_cnt = '0;
            end else if (sum > {1'b0, limit_q}) begin
                step_cnt = limit_q;
            end else begin
                step_cnt = sum[BITS-1:0];
            end
        end else begin
            if (count_q == '0) begin
                step_hit = 1'b1;
                if (!ctrl_q[CTRL_ONESHOT]) step_cnt = limit_q;
            end else if ({1'b0, count_q} <= STEP) begin
                step_cnt = '0;
            end else begin
                step_cnt = count_q - STEP[BITS-1:0];
            end
        end
    end

    // Step, then LA force, then bus write: later assignments take priority.
    always_comb begin
        do_step = ctrl_q[CTRL_EN] && !(wr_i && sel_i == REG_COUNT) && !force_i;
        count_d = count_q;
        limit_d = limit_q;
        ctrl_d  = ctrl_q;
        hit_d   = hit_q;
        if (do_step) begin
            count_d = step_cnt;
            if (step_hit) begin
                hit_d = 1'b1;
                if (ctrl_q[CTRL_ONESHOT]) ctrl_d[CTRL_EN] = 1'b0;
            end
        end
        if (force_i) begin
            count_d = (count_q & ~force_mask_i) | (force_val_i & force_mask_i);
        end
        if (wr_i) begin
            case (sel_i)
                REG_CTRL:   ctrl_d  = (ctrl_q & ~wmask_i[CTRL_W-1:0]) | (wdata_i[CTRL_W-1:0] & wmask_i[CTRL_W-1:0]);
                REG_COUNT:  count_d = (count_q & ~wmask) | (wdata & wmask);
                REG_LIMIT:  limit_d = (limit_q & ~wmask) | (wdata & wmask);
                REG_STATUS: if (wmask_i[0] && wdata_i[0] && !(do_step && step_hit)) hit_d = 1'b0;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            limit_q <= '1;
            ctrl_q  <= CTRL_RST;
            hit_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
            ctrl_q  <= ctrl_d;
            hit_q   <= hit_d;
        end
    end

    assign count_o = count_q;
    assign limit_o = limit_q;
    assign ctrl_o  = ctrl_q;
    assign hit_o   = hit_q;

endmodule

// File: rtl/multi_counter.sv
// Multi-channel counter/timer: bus decode, ready/rdata, LA force on OUT_CH and merged irq.
module multi_counter
    import multi_counter_pkg::*;
#(
    parameter int unsigned BITS       = 30,
    parameter int unsigned NCH        = 4,
    parameter int unsigned COUNT_STEP = 1,
    parameter int unsigned OUT_CH     = 0
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            valid,
    input  logic [3:0]      wstrb,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wdata,
    input  logic [BITS-1:0] la_write,
    input  logic [BITS-1:0] la_input,
    output logic            ready,
    output logic [31:0]     rdata,
    output logic [BITS-1:0] count_o,
    output logic [BITS-1:0] io_oeb,
    output logic            irq
);

    logic            ready_q, irq_q;
    logic [31:0]     rdata_q, rd_val, wmask;
    logic            accept, ch_ok, wr, la_force;
    logic [3:0]      ch_idx;
    reg_sel_e        sel;
    logic            unused_adr;

    logic [BITS-1:0]   cnt_a  [NCH];
    logic [BITS-1:0]   lim_a  [NCH];
    logic [CTRL_W-1:0] ctrl_a [NCH];
    logic [NCH-1:0]    hit_v, irq_en_v;

    assign accept     = valid && !ready_q;
    assign ch_idx     = wbs_adr_i[7:4];
    assign sel        = reg_sel_e'(wbs_adr_i[3:2]);
    assign ch_ok      = 32'(ch_idx) < NCH;
    assign wr         = accept && (wstrb != '0) && ch_ok;
    assign wmask      = byte_mask(wstrb);
    assign la_force   = |la_write;
    assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        counter_channel #(
            .BITS       (BITS),
            .COUNT_STEP (COUNT_STEP)
        ) u_ch (
            .clk_i        (wb_clk_i),
            .rst_ni       (wb_rst_ni),
            .wr_i         (wr && (ch_idx == 4'(g))),
            .sel_i        (sel),
            .wmask_i      (wmask),
            .wdata_i      (wdata),
            .force_i      (la_force && (g == OUT_CH)),
            .force_mask_i (la_write),
            .force_val_i  (la_input),
            .count_o      (cnt_a[g]),
            .limit_o      (lim_a[g]),
            .ctrl_o       (ctrl_a[g]),
            .hit_o        (hit_v[g])
        );
        assign irq_en_v[g] = ctrl_a[g][CTRL_IRQ_EN];
    end

    // Channels at or above NCH never match, so they read as zero.
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ch_idx == 4'(i)) begin
                case (sel)
                    REG_CTRL:   rd_val = 32'(ctrl_a[i]);
                    REG_COUNT:  rd_val = 32'(cnt_a[i]);
                    REG_LIMIT:  rd_val = 32'(lim_a[i]);
                    REG_STATUS: rd_val = 32'(hit_v[i]);
                    default:    rd_val = '0;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            ready_q <= accept;
            rdata_q <= accept ? rd_val : '0;
            irq_q   <= |(hit_v & irq_en_v);
        end
    end

    assign ready   = ready_q;
    assign rdata   = rdata_q;
    assign irq     = irq_q;
    assign count_o = cnt_a[OUT_CH];
    assign io_oeb  = {BITS{~wb_rst_ni}};

endmodule

// File: tb/tb_multi_counter.sv
// Scoreboard bench for multi_counter: randomized and directed bus traffic against a behavioural model.
module tb_multi_counter;

    localparam int unsigned BITS   = 30;
    localparam int unsigned NCH    = 4;
    localparam int unsigned STEP   = 1;
    localparam int unsigned OUT_CH = 0;
    localparam longint unsigned MAXV = (64'd1 << BITS) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid;
    logic [3:0]      wstrb;
    logic [31:0]     adr, wdata;
    logic [BITS-1:0] la_write, la_input;
    logic            ready, irq;
    logic [31:0]     rdata;
    logic [BITS-1:0] count_o, io_oeb;

    logic            rst3_n, v3, ready3, irq3;
    logic [3:0]      s3;
    logic [31:0]     a3, d3, rdata3;
    logic [7:0]      la3, count3, oeb3;
    bit              done3 = 1'b0;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    multi_counter #(.BITS(BITS), .NCH(NCH), .COUNT_STEP(STEP), .OUT_CH(OUT_CH)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .valid(valid), .wstrb(wstrb), .wbs_adr_i(adr),
        .wdata(wdata), .la_write(la_write), .la_input(la_input), .ready(ready), .rdata(rdata),
        .count_o(count_o), .io_oeb(io_oeb), .irq(irq));

    multi_counter #(.BITS(8), .NCH(2), .COUNT_STEP(3), .OUT_CH(0)) dut3 (
        .wb_clk_i(clk), .wb_rst_ni(rst3_n), .valid(v3), .wstrb(s3), .wbs_adr_i(a3),
        .wdata(d3), .la_write(la3), .la_input(la3), .ready(ready3), .rdata(rdata3),
        .count_o(count3), .io_oeb(oeb3), .irq(irq3));

    // Reference state, one entry per channel.
    longint unsigned m_cnt [NCH];
    longint unsigned m_lim [NCH];
    bit [3:0]        m_ctrl[NCH];
    bit              m_hit [NCH];
    bit              m_irq, m_ready;
    bit [31:0]       exp_q[$];
    bit [31:0]       mon_exp;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw, input bit [3:0] s);
        bit [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic bit [31:0] addr(input int unsigned ch, input int unsigned sel);
        return 32'((ch << 4) | (sel << 2));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_lim[i] = MAXV; m_ctrl[i] = 0; m_hit[i] = 0;
        end
        m_irq = 0; m_ready = 0;
        exp_q.delete();
    endtask

    // Applies one clock edge worth of the counter rules to the reference state.
    task automatic model_edge();
        bit acc, new_irq;
        int unsigned ch, sel;
        bit [31:0] rd;
        longint unsigned lw, li;
        acc = valid && !m_ready;
        ch  = int'(adr[7:4]);
        sel = int'(adr[3:2]);
        lw  = la_write;
        li  = la_input;
        new_irq = 0;
        for (int i = 0; i < NCH; i++) if (m_hit[i] && m_ctrl[i][3]) new_irq = 1;
        if (acc) begin
            rd = 0;
            if (ch < NCH) begin
                case (sel)
                    0: rd = 32'(m_ctrl[ch]);
                    1: rd = 32'(m_cnt[ch]);
                    2: rd = 32'(m_lim[ch]);
                    default: rd = 32'(m_hit[ch]);
                endcase
            end
            exp_q.push_back(rd);
        end
        for (int i = 0; i < NCH; i++) begin
            bit wr, cw, frc, hit_now, h;
            bit [3:0] ct;
            longint unsigned c, l;
            wr  = acc && wstrb != 0 && ch == i;
            cw  = wr && sel == 1;
            frc = (i == OUT_CH) && lw != 0;
            c = m_cnt[i]; l = m_lim[i]; ct = m_ctrl[i]; h = m_hit[i]; hit_now = 0;
            if (ct[0] && !cw && !frc) begin
                if (!ct[1]) begin
                    if (c >= l) begin hit_now = 1; if (!ct[2]) c = 0; end
                    else c = (c + STEP > l) ? l : c + STEP;
                end else begin
                    if (c == 0) begin hit_now = 1; if (!ct[2]) c = l; end
                    else c = (c > STEP) ? c - STEP : 0;
                end
                if (hit_now) begin h = 1; if (ct[2]) ct[0] = 0; end
            end
            if (frc) c = (m_cnt[i] & ~lw) | (li & lw);
            if (wr) begin
                case (sel)
                    0: ct = 4'(merge(32'(m_ctrl[i]), wdata, wstrb));
                    1: c  = merge(32'(m_cnt[i]), wdata, wstrb) & MAXV;
                    2: l  = merge(32'(m_lim[i]), wdata, wstrb) & MAXV;
                    default: if (wstrb[0] && wdata[0] && !hit_now) h = 0;
                endcase
            end
            m_cnt[i] = c; m_lim[i] = l; m_ctrl[i] = ct; m_hit[i] = h;
        end
        m_irq = new_irq;
        m_ready = acc;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("count_o", count_o, m_cnt[OUT_CH]);
        check("irq", irq, m_irq);
        check("ready", ready, m_ready);
    endtask

    task automatic bus(input bit [31:0] a, input bit [3:0] s, input bit [31:0] d);
        valid = 1; adr = a; wstrb = s; wdata = d;
        step();
        valid = 0; wstrb = 0;
        step();
    endtask

    // Monitor: every ready beat consumes one expected read value.
    always @(negedge clk) begin
        if (rst_n && ready) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL spurious_ready: got ready=1, expected no pending request at %0t", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rdata", rdata, mon_exp);
            end
        end
    end

    task automatic bus3(input bit [31:0] a, input bit [31:0] d);
        v3 = 1; a3 = a; s3 = 4'hF; d3 = d;
        @(posedge clk);
        @(negedge clk);
        check("s3_ready", ready3, 1);
        v3 = 0; s3 = 0;
    endtask

    initial begin
        int unsigned exp3 [6];
        exp3 = '{0, 3, 6, 9, 10, 0};
        rst3_n = 0; v3 = 0; s3 = 0; a3 = 0; d3 = 0; la3 = 0;
        repeat (3) @(negedge clk);
        rst3_n = 1;
        bus3(addr(0, 2), 10);
        @(negedge clk);
        bus3(addr(0, 0), 1);
        for (int i = 0; i < 6; i++) begin
            check("s3_count", count3, exp3[i]);
            @(negedge clk);
        end
        done3 = 1;
    end

    initial begin
        rst_n = 0; valid = 0; wstrb = 0; adr = 0; wdata = 0; la_write = 0; la_input = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_rdata", rdata, 0);
        check("rst_irq", irq, 0);
        check("rst_count", count_o, 0);
        check("rst_oeb", io_oeb, MAXV);
        rst_n = 1;
        model_reset();
        step();
        check("oeb_run", io_oeb, 0);
        bus(addr(0, 2), 4'h0, 0);

        // Channel 1 up/wrap at LIMIT=5, then stop and W1C.
        bus(addr(1, 2), 4'hF, 5);
        bus(addr(1, 0), 4'hF, 1);
        repeat (4) bus(addr(1, 1), 4'h0, 0);
        bus(addr(1, 3), 4'h0, 0);
        bus(addr(1, 0), 4'hF, 0);
        bus(addr(1, 3), 4'h1, 1);
        bus(addr(1, 3), 4'h0, 0);

        // Channel 2 down from 3 with reload to 7.
        bus(addr(2, 1), 4'hF, 3);
        bus(addr(2, 2), 4'hF, 7);
        bus(addr(2, 0), 4'hF, 3);
        repeat (4) bus(addr(2, 1), 4'h0, 0);
        bus(addr(2, 3), 4'h0, 0);

        // Channel 3 with LIMIT=0 counting up.
        bus(addr(3, 2), 4'hF, 0);
        bus(addr(3, 0), 4'hF, 1);
        bus(addr(3, 1), 4'h0, 0);
        bus(addr(3, 3), 4'h0, 0);
        bus(addr(3, 0), 4'hF, 0);

        // Bus write to COUNT beats LA force; LA alone then patches the low byte.
        bus(addr(0, 0), 4'hF, 1);
        valid = 1; adr = addr(0, 1); wstrb = 4'hF; wdata = 32'h100;
        la_write = BITS'(32'hFF); la_input = BITS'(32'hA5);
        step();
        check("bus_over_la", count_o, 32'h100);
        valid = 0; wstrb = 0;
        step();
        check("la_force", count_o, 32'h1A5);
        la_write = 0;
        step();

        // Back-to-back requests with valid held high.
        valid = 1; adr = addr(0, 2); wstrb = 0;
        repeat (4) step();
        valid = 0;
        step();

        // Channel 0 one-shot with irq.
        bus(addr(0, 0), 4'hF, 0);
        bus(addr(0, 1), 4'hF, 0);
        bus(addr(0, 2), 4'hF, 2);
        bus(addr(0, 0), 4'hF, 32'hD);
        repeat (6) step();
        check("oneshot_hold", count_o, 2);
        check("oneshot_irq", irq, 1);
        bus(addr(0, 0), 4'h0, 0);

        // Out-of-range channel, then reset while a request is acknowledged.
        bus(addr(5, 1), 4'hF, 32'h55);
        bus(addr(5, 1), 4'h0, 0);
        valid = 1; adr = addr(1, 1); wstrb = 0;
        @(posedge clk);
        model_edge();
        #2 rst_n = 0;
        #1;
        check("async_ready", ready, 0);
        check("async_rdata", rdata, 0);
        check("async_irq", irq, 0);
        check("async_count", count_o, 0);
        model_reset();
        @(negedge clk);
        valid = 0;
        rst_n = 1;
        bus(addr(0, 2), 4'h0, 0);
        bus(addr(0, 0), 4'h0, 0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            int unsigned ch, sel;
            bit [3:0] s;
            bit [31:0] d;
            ch  = $urandom_range(0, 7);
            sel = $urandom_range(0, 3);
            s   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            case (sel)
                0: d = $urandom_range(0, 15);
                1, 2: d = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 12);
                default: d = $urandom;
            endcase
            la_write = ($urandom_range(0, 3) == 0) ? BITS'($urandom_range(1, 255)) : '0;
            la_input = BITS'($urandom);
            bus(addr(ch, sel), s, d);
            la_write = 0;
            repeat ($urandom_range(0, 2)) step();
        end

        for (int k = 0; k < 200 && !done3; k++) @(negedge clk);
        check("s3_done", done3, 1);
        check("ready_missing", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
